keccak_msg_padder: RTL and testbench

// Upstream stage of the Keccak control unit. Accepts a message as a stream of 64-bit words.

---
 rtl/keccak_msg_padder.sv | 159 +++++++++++++++
 tb/tb_keccak_msg_padder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_msg_padder.sv
// Keccak message padder: packs 64-bit little-endian message words into rate-sized blocks,
// applies SHA-3/SHAKE multi-rate padding and presents each 1600-bit state image downstream.
module keccak_msg_padder #(
  parameter int unsigned D_WIDTH        = 1600,
  parameter int unsigned D_KECCAK_WIDTH = 64,
  parameter int unsigned RATE_LANES     = 17,
  parameter logic [7:0]  DSEP           = 8'h06
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [D_KECCAK_WIDTH-1:0] msg_i,
  input  logic                      msg_valid_i,
  input  logic                      msg_last_i,
  input  logic [3:0]                msg_bytes_i,
  output logic                      msg_ready_o,
  output logic [D_WIDTH-1:0]        block_o,
  output logic                      block_valid_o,
  output logic                      block_last_o,
  input  logic                      block_ready_i
);

  localparam int unsigned         RB           = RATE_LANES * 8;
  localparam logic [7:0]          RB_B         = 8'(RB);
  localparam logic [4:0]          LAST_CNT     = 5'(RATE_LANES - 1);
  localparam logic [10:0]         PAD_BYTE_POS = 11'((RB - 1) * 8);
  localparam logic [D_WIDTH-1:0]  RATE_MASK    = {{(D_WIDTH - RB * 8){1'b0}}, {(RB * 8){1'b1}}};

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  function automatic logic [3:0] sat_bytes(input logic [3:0] b);
    return (b > 4'd8) ? 4'd8 : b;
  endfunction

  function automatic logic [D_KECCAK_WIDTH-1:0] keep_mask(input logic [3:0] n);
    logic [D_KECCAK_WIDTH-1:0] m;
    m = {D_KECCAK_WIDTH{1'b0}};
    for (int i = 0; i < D_KECCAK_WIDTH / 8; i++) begin
      m[8*i +: 8] = (4'(i) < n) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  function automatic logic [D_WIDTH-1:0] pad_only_block();
    logic [D_WIDTH-1:0] b;
    b = {D_WIDTH{1'b0}};
    b[7:0] = DSEP;
    b[PAD_BYTE_POS +: 8] = b[PAD_BYTE_POS +: 8] ^ 8'h80;
    return b;
  endfunction

  localparam logic [D_WIDTH-1:0] PAD_BLOCK = pad_only_block();

  state_e               state_q;
  logic [4:0]           cnt_q;
  logic [D_WIDTH-1:0]   buf_q;
  logic                 pad_pending_q;
  logic                 msg_ready_q;
  logic                 block_valid_q;
  logic                 block_last_q;

  logic [3:0]                nbytes_s;
  logic [D_KECCAK_WIDTH-1:0] word_s;
  logic [7:0]                p_s;
  logic                      pad_here_s;
  logic [10:0]               lane_base_s;
  logic [D_WIDTH-1:0]        fill_buf_d;
  logic                      word_xfer_s;
  logic                      block_xfer_s;

  // Buffer image after absorbing the current word, padding bytes XORed in when the message ends inside the rate.
  always_comb begin
    nbytes_s    = msg_last_i ? sat_bytes(msg_bytes_i) : 4'd8;
    word_s      = msg_i & keep_mask(nbytes_s);
    p_s         = {cnt_q, 3'b000} + {4'b0000, nbytes_s};
    pad_here_s  = msg_last_i && (p_s < RB_B);
    lane_base_s = {cnt_q, 6'b000000};
    fill_buf_d  = buf_q;
    fill_buf_d[lane_base_s +: D_KECCAK_WIDTH] = word_s;
    fill_buf_d[{p_s, 3'b000} +: 8] = fill_buf_d[{p_s, 3'b000} +: 8] ^ (pad_here_s ? DSEP : 8'h00);
    fill_buf_d[PAD_BYTE_POS +: 8]  = fill_buf_d[PAD_BYTE_POS +: 8] ^ (pad_here_s ? 8'h80 : 8'h00);
    fill_buf_d  = fill_buf_d & RATE_MASK;
  end

  assign word_xfer_s  = msg_valid_i && msg_ready_q;
  assign block_xfer_s = block_valid_q && block_ready_i;

  // Control FSM with registered handshake outputs and block buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_FILL;
      cnt_q         <= 5'd0;
      buf_q         <= {D_WIDTH{1'b0}};
      pad_pending_q <= 1'b0;
      msg_ready_q   <= 1'b1;
      block_valid_q <= 1'b0;
      block_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (word_xfer_s) begin
            buf_q <= fill_buf_d;
            if (msg_last_i) begin
              // A message ending exactly on the rate boundary needs a separate pad-only block.
              state_q       <= S_EMIT;
              msg_ready_q   <= 1'b0;
              block_valid_q <= 1'b1;
              block_last_q  <= (p_s != RB_B);
              pad_pending_q <= (p_s == RB_B);
            end else if (cnt_q == LAST_CNT) begin
              state_q       <= S_EMIT;
              msg_ready_q   <= 1'b0;
              block_valid_q <= 1'b1;
              block_last_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        S_EMIT: begin
          if (block_xfer_s) begin
            buf_q         <= {D_WIDTH{1'b0}};
            cnt_q         <= 5'd0;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
            state_q       <= pad_pending_q ? S_PAD : S_FILL;
            msg_ready_q   <= !pad_pending_q;
          end
        end
        S_PAD: begin
          buf_q         <= PAD_BLOCK;
          pad_pending_q <= 1'b0;
          state_q       <= S_EMIT;
          block_valid_q <= 1'b1;
          block_last_q  <= 1'b1;
          msg_ready_q   <= 1'b0;
        end
        default: begin
          state_q       <= S_FILL;
          cnt_q         <= 5'd0;
          buf_q         <= {D_WIDTH{1'b0}};
          pad_pending_q <= 1'b0;
          msg_ready_q   <= 1'b1;
          block_valid_q <= 1'b0;
          block_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign msg_ready_o   = msg_ready_q;
  assign block_o       = buf_q;
  assign block_valid_o = block_valid_q;
  assign block_last_o  = block_last_q;

endmodule

// File: tb/tb_keccak_msg_padder.sv
// Bench for keccak_msg_padder: byte-level SHA-3 padding model with a block scoreboard,
// plus directed literal checks for the characteristic message lengths.
module tb_keccak_msg_padder;

  localparam int         RATE = 17;
  localparam int         RB   = RATE * 8;
  localparam logic [7:0] DSEP = 8'h06;

  typedef logic [7:0] byte_q_t [$];

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [63:0]   msg_i;
  logic          msg_valid_i;
  logic          msg_last_i;
  logic [3:0]    msg_bytes_i;
  logic          msg_ready_o;
  logic [1599:0] block_o;
  logic          block_valid_o;
  logic          block_last_o;
  logic          block_ready_i;

  logic [1599:0] exp_blk [$];
  logic          exp_last [$];
  int            n_checks = 0;
  int            n_pass   = 0;

  keccak_msg_padder #(
    .D_WIDTH(1600), .D_KECCAK_WIDTH(64), .RATE_LANES(RATE), .DSEP(DSEP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .msg_i(msg_i), .msg_valid_i(msg_valid_i),
    .msg_last_i(msg_last_i), .msg_bytes_i(msg_bytes_i), .msg_ready_o(msg_ready_o),
    .block_o(block_o), .block_valid_o(block_valid_o), .block_last_o(block_last_o),
    .block_ready_i(block_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] lane(input int i);
    return block_o[i*64 +: 64];
  endfunction

  function automatic logic [63:0] or_lanes(input int lo, input int hi);
    logic [63:0] r;
    r = 64'd0;
    for (int i = lo; i <= hi; i++) r = r | block_o[i*64 +: 64];
    return r;
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference padding: append DSEP .. 0x80 (merged when one byte remains), then cut into rate blocks.
  task automatic model_msg(input byte_q_t m);
    byte_q_t       pm;
    logic [1599:0] blk;
    int            nblk;
    pm = m;
    if (pm.size() % RB == RB - 1) begin
      pm.push_back(DSEP | 8'h80);
    end else begin
      pm.push_back(DSEP);
      while (pm.size() % RB != RB - 1) pm.push_back(8'h00);
      pm.push_back(8'h80);
    end
    nblk = pm.size() / RB;
    for (int b = 0; b < nblk; b++) begin
      blk = 1600'd0;
      for (int i = 0; i < RB; i++) blk[i*8 +: 8] = pm[b*RB + i];
      exp_blk.push_back(blk);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  task automatic model_compare();
    int bad;
    if (rst_ni === 1'b1 && block_valid_o === 1'b1) begin
      n_checks++;
      if (exp_blk.size() == 0) begin
        $display("FAIL unexpected_block: block_valid_o=1 but no block is expected");
      end else begin
        bad = -1;
        for (int l = 0; l < 25; l++)
          if (bad < 0 && block_o[l*64 +: 64] !== exp_blk[0][l*64 +: 64]) bad = l;
        if (bad >= 0)
          $display("FAIL block_image lane %0d: got %h expected %h", bad, block_o[bad*64 +: 64], exp_blk[0][bad*64 +: 64]);
        else if (block_last_o !== exp_last[0])
          $display("FAIL block_last: got %b expected %b", block_last_o, exp_last[0]);
        else
          n_pass++;
      end
    end
  endtask

  // One clock: retire a handshaken block from the scoreboard, pass the edge, compare at the falling edge.
  task automatic step();
    if (rst_ni === 1'b1 && block_valid_o === 1'b1 && block_ready_i === 1'b1 && exp_blk.size() > 0) begin
      exp_blk.pop_front();
      exp_last.pop_front();
    end
    @(posedge clk_i);
    @(negedge clk_i);
    model_compare();
  endtask

  task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] nb);
    int waitc;
    waitc = 0;
    msg_i = w; msg_last_i = last; msg_bytes_i = nb; msg_valid_i = 1'b1;
    while (msg_ready_o !== 1'b1 && waitc < 200) begin
      step();
      waitc++;
    end
    if (msg_ready_o === 1'b1) begin
      step();
    end else begin
      n_checks++;
      $display("FAIL msg_ready_timeout: msg_ready_o=%b after %0d cycles, required 1", msg_ready_o, waitc);
    end
    msg_valid_i = 1'b0; msg_last_i = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t m, input logic [7:0] junk);
    int          len;
    int          nw;
    int          nb;
    logic [63:0] w;
    len = m.size();
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    model_msg(m);
    for (int wi = 0; wi < nw; wi++) begin
      nb = len - wi * 8;
      if (nb > 8) nb = 8;
      for (int k = 0; k < 8; k++) w[k*8 +: 8] = (k < nb) ? m[wi*8 + k] : junk;
      send_word(w, wi == nw - 1, 4'(nb));
    end
  endtask

  function automatic byte_q_t abc_msg();
    byte_q_t q;
    q = {};
    q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63);
    return q;
  endfunction

  initial begin
    byte_q_t m;
    byte_q_t m8;
    rst_ni = 1'b0; msg_i = 64'd0; msg_valid_i = 1'b0; msg_last_i = 1'b0;
    msg_bytes_i = 4'd0; block_ready_i = 1'b1;
    @(negedge clk_i);
    step(); step();
    chk64("reset_block_valid", 64'(block_valid_o), 64'd0);
    chk64("reset_block_last", 64'(block_last_o), 64'd0);
    chk64("reset_msg_ready", 64'(msg_ready_o), 64'd1);
    chk64("reset_block_zero", or_lanes(0, 24), 64'd0);
    rst_ni = 1'b1;
    step();

    // Empty message
    m = {};
    send_msg(m, 8'h00);
    chk64("t1_valid", 64'(block_valid_o), 64'd1);
    chk64("t1_last", 64'(block_last_o), 64'd1);
    chk64("t1_lane0", lane(0), 64'h06);
    chk64("t1_lane16", lane(16), 64'h8000_0000_0000_0000);
    chk64("t1_other_lanes", or_lanes(1, 15) | or_lanes(17, 24), 64'd0);
    step(); step();

    // "abc" with junk in the unused bytes
    send_msg(abc_msg(), 8'h5A);
    chk64("t2_lane0", lane(0), 64'h0000_0000_0663_6261);
    chk64("t2_lane16", lane(16), 64'h8000_0000_0000_0000);
    chk64("t2_last", 64'(block_last_o), 64'd1);
    step(); step();

    // 135 bytes: DSEP and 0x80 share the final rate byte
    m = {};
    for (int i = 0; i < 128; i++) m.push_back(8'(i + 1));
    m.push_back(8'h77); m.push_back(8'h66); m.push_back(8'h55); m.push_back(8'h44);
    m.push_back(8'h33); m.push_back(8'h22); m.push_back(8'h11);
    send_msg(m, 8'hAA);
    chk64("t3_last", 64'(block_last_o), 64'd1);
    chk64("t3_lane0", lane(0), 64'h0807_0605_0403_0201);
    chk64("t3_lane16", lane(16), 64'h8611_2233_4455_6677);
    step(); step();

    // 136 bytes: full data block, PAD cycle, then pad-only block
    m = {};
    for (int i = 0; i < 136; i++) m.push_back(8'(i * 3));
    send_msg(m, 8'h00);
    chk64("t4_data_valid", 64'(block_valid_o), 64'd1);
    chk64("t4_data_last", 64'(block_last_o), 64'd0);
    step();
    chk64("t4_pad_gap_valid", 64'(block_valid_o), 64'd0);
    chk64("t4_pad_gap_ready", 64'(msg_ready_o), 64'd0);
    step();
    chk64("t4_pad_valid", 64'(block_valid_o), 64'd1);
    chk64("t4_pad_last", 64'(block_last_o), 64'd1);
    chk64("t4_pad_lane0", lane(0), 64'h06);
    chk64("t4_pad_lane16", lane(16), 64'h8000_0000_0000_0000);
    chk64("t4_pad_lane5", lane(5), 64'd0);
    step(); step();

    // Downstream stall with a word offered the whole time
    block_ready_i = 1'b0;
    send_msg(abc_msg(), 8'h00);
    msg_i = 64'hDEAD_BEEF_CAFE_F00D; msg_last_i = 1'b1; msg_bytes_i = 4'd8; msg_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk64("t5_valid", 64'(block_valid_o), 64'd1);
      chk64("t5_last", 64'(block_last_o), 64'd1);
      chk64("t5_msg_ready", 64'(msg_ready_o), 64'd0);
      chk64("t5_lane0", lane(0), 64'h0000_0000_0663_6261);
      step();
    end
    msg_valid_i = 1'b0; msg_last_i = 1'b0; block_ready_i = 1'b1;
    step();
    chk64("t5_after_valid", 64'(block_valid_o), 64'd0);
    chk64("t5_after_ready", 64'(msg_ready_o), 64'd1);
    step(); step(); step();

    // Reset mid-message discards the partial block
    for (int i = 0; i < 5; i++) send_word(64'h1111_1111_1111_1111 * 64'(i + 1), 1'b0, 4'd8);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk64("t6_valid", 64'(block_valid_o), 64'd0);
    chk64("t6_ready", 64'(msg_ready_o), 64'd1);
    chk64("t6_block_zero", or_lanes(0, 24), 64'd0);
    send_msg(abc_msg(), 8'h00);
    chk64("t6_lane0", lane(0), 64'h0000_0000_0663_6261);
    chk64("t6_lane16", lane(16), 64'h8000_0000_0000_0000);
    chk64("t6_last", 64'(block_last_o), 64'd1);
    step(); step();

    // Byte count above 8 saturates to a full word
    m8 = {};
    for (int i = 0; i < 8; i++) m8.push_back(8'(i + 1));
    model_msg(m8);
    send_word(64'h0807_0605_0403_0201, 1'b1, 4'hF);
    chk64("t7_lane0", lane(0), 64'h0807_0605_0403_0201);
    chk64("t7_lane1", lane(1), 64'h06);
    chk64("t7_lane16", lane(16), 64'h8000_0000_0000_0000);
    step(); step();

    // Two-block message, partial final word
    m = {};
    for (int i = 0; i < 157; i++) m.push_back(8'(i * 7 + 3));
    send_msg(m, 8'hC3);
    for (int i = 0; i < 6; i++) step();
    chk64("all_blocks_emitted", 64'(exp_blk.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
